// File: rtl/hazard_control_unit_if.sv
// Bundle of pipeline-side signals between the hazard controller and the core datapath.
// The controller takes the slave view; the core or bench drives through the master view.
interface hazard_control_unit_if #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic                  id_ex_memRead;
    logic [REG_ADDR_W-1:0] id_ex_registerRD;
    logic [REG_ADDR_W-1:0] if_id_registerA;
    logic [REG_ADDR_W-1:0] if_id_registerB;
    logic                  if_id_useA;
    logic                  if_id_useB;
    logic                  branch_taken;
    logic                  ex_busy;
    logic                  perf_clear;
    logic                  enablePC;
    logic                  if_id_enable;
    logic                  if_id_flush;
    logic                  muxSelector;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_ex_memRead, id_ex_registerRD, if_id_registerA, if_id_registerB,
        output if_id_useA, if_id_useB, branch_taken, ex_busy, perf_clear,
        input  enablePC, if_id_enable, if_id_flush, muxSelector, stall_count
    );

    modport slave (
        input  id_ex_memRead, id_ex_registerRD, if_id_registerA, if_id_registerB,
        input  if_id_useA, if_id_useB, branch_taken, ex_busy, perf_clear,
        output enablePC, if_id_enable, if_id_flush, muxSelector, stall_count
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Load-use stall, branch flush and EX-busy freeze controller for the IF/ID and ID/EX stages.
// Controls are combinational from state, so a hazard stalls the front end in the cycle it appears.
module hazard_control_unit #(
    parameter int REG_ADDR_W         = 4,
    parameter int LOAD_LATENCY       = 1,
    parameter int FLUSH_CYCLES       = 1,
    parameter int ZERO_REG_HARDWIRED = 1,
    parameter int CNT_W              = 16
) (
    input logic              clock,
    input logic              reset_n,
    hazard_control_unit_if.slave bus
);

    typedef enum logic [1:0] {RUN, LSTALL, FLUSH} state_t;

    localparam bit         LOAD_MULTI   = (LOAD_LATENCY > 1);
    localparam bit         FLUSH_MULTI  = (FLUSH_CYCLES > 1);
    localparam logic [3:0] LOAD_RELOAD  = 4'(LOAD_LATENCY - 1);
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [3:0]       cnt;
    logic             hz;
    logic             enable_pc;
    logic             enable_ifid;
    logic             flush_ifid;
    logic             bubble;
    logic [CNT_W-1:0] stall_q;

    always_comb begin
        hz = bus.id_ex_memRead &&
             ((bus.if_id_useA && (bus.id_ex_registerRD == bus.if_id_registerA)) ||
              (bus.if_id_useB && (bus.id_ex_registerRD == bus.if_id_registerB)));
        if ((ZERO_REG_HARDWIRED != 0) && (bus.id_ex_registerRD == '0))
            hz = 1'b0;
    end

    // ex_busy outranks a branch, which outranks any load-use stall in progress
    always_comb begin
        enable_pc   = 1'b1;
        enable_ifid = 1'b1;
        flush_ifid  = 1'b0;
        bubble      = 1'b0;
        if (bus.ex_busy) begin
            enable_pc   = 1'b0;
            enable_ifid = 1'b0;
        end else if (bus.branch_taken || (state == FLUSH)) begin
            flush_ifid = 1'b1;
            bubble     = 1'b1;
        end else if ((state == LSTALL) || hz) begin
            enable_pc   = 1'b0;
            enable_ifid = 1'b0;
            bubble      = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            cnt   <= '0;
        end else if (!bus.ex_busy) begin
            if (bus.branch_taken) begin
                if (FLUSH_MULTI) begin
                    state <= FLUSH;
                    cnt   <= FLUSH_RELOAD;
                end else begin
                    state <= RUN;
                    cnt   <= '0;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (hz && LOAD_MULTI) begin
                            state <= LSTALL;
                            cnt   <= LOAD_RELOAD;
                        end
                    end
                    LSTALL, FLUSH: begin
                        if (cnt <= 4'd1) begin
                            state <= RUN;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    default: begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stall_q <= '0;
        else if (bus.perf_clear)
            stall_q <= '0;
        else if (!enable_pc && (stall_q != CNT_MAX))
            stall_q <= stall_q + 1'b1;
    end

    assign bus.enablePC     = enable_pc;
    assign bus.if_id_enable = enable_ifid;
    assign bus.if_id_flush  = flush_ifid;
    assign bus.muxSelector  = bubble;
    assign bus.stall_count  = stall_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: dut_a (LOAD_LATENCY=3, FLUSH_CYCLES=2) runs a per-cycle vector table,
// dut_b (LOAD_LATENCY=1, FLUSH_CYCLES=1, CNT_W=2) covers single-cycle cases and saturation.
module tb_hazard_control_unit;

    typedef struct {
        logic        mr;
        logic [3:0]  rd;
        logic [3:0]  a;
        logic [3:0]  b;
        logic        ua;
        logic        ub;
        logic        br;
        logic        busy;
        logic        clr;
        logic [3:0]  ctrl;
        logic [15:0] cnt;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];

    hazard_control_unit_if #(.REG_ADDR_W(4), .CNT_W(16)) ifa ();
    hazard_control_unit_if #(.REG_ADDR_W(4), .CNT_W(2))  ifb ();

    hazard_control_unit #(
        .REG_ADDR_W(4), .LOAD_LATENCY(3), .FLUSH_CYCLES(2),
        .ZERO_REG_HARDWIRED(1), .CNT_W(16)
    ) dut_a (
        .clock(clock),
        .reset_n(reset_n),
        .bus(ifa)
    );

    hazard_control_unit #(
        .REG_ADDR_W(4), .LOAD_LATENCY(1), .FLUSH_CYCLES(1),
        .ZERO_REG_HARDWIRED(1), .CNT_W(2)
    ) dut_b (
        .clock(clock),
        .reset_n(reset_n),
        .bus(ifb)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic mr, input logic [3:0] rd, input logic [3:0] a,
                                input logic [3:0] b, input logic ua, input logic ub,
                                input logic br, input logic busy, input logic clr,
                                input logic [3:0] ctrl, input logic [15:0] cnt);
        vec_t v;
        v.mr = mr; v.rd = rd; v.a = a; v.b = b; v.ua = ua; v.ub = ub;
        v.br = br; v.busy = busy; v.clr = clr; v.ctrl = ctrl; v.cnt = cnt;
        return v;
    endfunction

    task automatic applyStimulus(input bit which, input vec_t v);
        if (which == 1'b0) begin
            ifa.id_ex_memRead = v.mr;  ifa.id_ex_registerRD = v.rd;
            ifa.if_id_registerA = v.a; ifa.if_id_registerB = v.b;
            ifa.if_id_useA = v.ua;     ifa.if_id_useB = v.ub;
            ifa.branch_taken = v.br;   ifa.ex_busy = v.busy;
            ifa.perf_clear = v.clr;
        end else begin
            ifb.id_ex_memRead = v.mr;  ifb.id_ex_registerRD = v.rd;
            ifb.if_id_registerA = v.a; ifb.if_id_registerB = v.b;
            ifb.if_id_useA = v.ua;     ifb.if_id_useB = v.ub;
            ifb.branch_taken = v.br;   ifb.ex_busy = v.busy;
            ifb.perf_clear = v.clr;
        end
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkBoth(input bit which, input vec_t v, input string name);
        if (which == 1'b0) begin
            checkOutput({name, ".ctrl"},
                        {12'd0, ifa.enablePC, ifa.if_id_enable, ifa.if_id_flush, ifa.muxSelector},
                        {12'd0, v.ctrl});
            checkOutput({name, ".count"}, ifa.stall_count, v.cnt);
        end else begin
            checkOutput({name, ".ctrl"},
                        {12'd0, ifb.enablePC, ifb.if_id_enable, ifb.if_id_flush, ifb.muxSelector},
                        {12'd0, v.ctrl});
            checkOutput({name, ".count"}, {14'd0, ifb.stall_count}, v.cnt);
        end
    endtask

    // Drive mid-cycle, sample 1 ns later; the count seen is the one before this cycle's edge
    task automatic runVec(input bit which, input vec_t v, input string name);
        @(negedge clock);
        applyStimulus(which, v);
        #1;
        checkBoth(which, v, name);
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 16'd0);
        applyStimulus(0, idle);
        applyStimulus(1, idle);
        #2;
        checkBoth(0, idle, "reset_a");
        checkBoth(1, idle, "reset_b");
        @(negedge clock);
        reset_n = 1'b1;

        // dut_b: single-cycle stall, single-cycle flush, counter saturation and clear
        runVec(1, mk(1, 3, 3, 0, 1, 0, 0, 0, 0, 4'b0001, 16'd0), "b_hz1");
        runVec(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 16'd1), "b_hz1_done");
        runVec(1, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 16'd1), "b_br1");
        runVec(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 16'd1), "b_br1_done");
        runVec(1, mk(1, 3, 3, 0, 1, 0, 0, 0, 0, 4'b0001, 16'd1), "b_sat0");
        runVec(1, mk(1, 3, 3, 0, 1, 0, 0, 0, 0, 4'b0001, 16'd2), "b_sat1");
        runVec(1, mk(1, 3, 3, 0, 1, 0, 0, 0, 0, 4'b0001, 16'd3), "b_sat2");
        runVec(1, mk(1, 3, 3, 0, 1, 0, 0, 0, 0, 4'b0001, 16'd3), "b_sat3");
        runVec(1, mk(1, 3, 3, 0, 1, 0, 0, 0, 0, 4'b0001, 16'd3), "b_sat4");
        runVec(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 16'd3), "b_sat_hold");
        runVec(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1100, 16'd3), "b_clear");
        runVec(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 16'd0), "b_cleared");

        // dut_a per-cycle table: ctrl = {enablePC, if_id_enable, if_id_flush, muxSelector}
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 16'd0));
        tbl.push_back(mk(1, 3, 3, 0, 1, 0, 0, 0, 0, 4'b0001, 16'd0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 16'd1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 16'd2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 16'd3));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1100, 16'd3));
        tbl.push_back(mk(1, 5, 2, 5, 1, 0, 0, 0, 0, 4'b1100, 16'd3));
        tbl.push_back(mk(1, 5, 2, 5, 1, 1, 0, 0, 0, 4'b0001, 16'd3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 16'd4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 16'd5));
        tbl.push_back(mk(1, 7, 7, 0, 1, 0, 0, 0, 0, 4'b0001, 16'd6));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 16'd7));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 16'd7));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 16'd7));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 16'd7));
        tbl.push_back(mk(1, 4, 4, 0, 1, 0, 0, 0, 0, 4'b1111, 16'd7));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 16'd7));
        tbl.push_back(mk(1, 3, 3, 0, 1, 0, 0, 0, 0, 4'b0001, 16'd7));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 16'd8));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 4'b0000, 16'd9));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 16'd10));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 16'd11));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 16'd12));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 16'd13));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 16'd14));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 16'd14));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 16'd14));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 16'd14));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 16'd14));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1100, 16'd14));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 16'd0));
        tbl.push_back(mk(1, 3, 3, 0, 1, 0, 0, 1, 0, 4'b0000, 16'd0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 16'd1));
        tbl.push_back(mk(1, 3, 3, 0, 1, 0, 0, 0, 1, 4'b0001, 16'd1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 16'd0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 16'd1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 16'd2));

        for (int i = 0; i < tbl.size(); i++)
            runVec(0, tbl[i], $sformatf("a_row%0d", i));

        // Asynchronous reset in the middle of a flush window
        runVec(0, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 16'd2), "a_rst_branch");
        runVec(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 16'd2), "a_rst_inflush");
        reset_n = 1'b0;
        #1;
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 16'd0);
        checkBoth(0, v, "a_async_reset");
        checkBoth(1, v, "b_async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        runVec(0, v, "a_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Parametrised sequential hazard controller for the pipelined core, sitting between the IF/ID and ID/EX pipeline registers. It detects load-use hazards and holds the front end for a configurable number of cycles. It flushes IF/ID for a configurable number of cycles after a taken branch and freezes the front end while a multi-cycle EX operation is busy. It also keeps a saturating stall-cycle performance counter.

Parameters:
REG_ADDR_W, 4, width of register specifiers.
LOAD_LATENCY, 1, bubble cycles inserted per load-use hazard (1..15).
FLUSH_CYCLES, 1, cycles of IF/ID flush after a taken branch (1..15).
ZERO_REG_HARDWIRED, 1, when 1, register 0 never causes a hazard.
CNT_W, 16, width of stall_count.

Ports:
clock  in  1  single clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
id_ex_memRead  in  1  instruction in ID/EX is a load.
id_ex_registerRD  in  REG_ADDR_W  destination register of ID/EX.
if_id_registerA  in  REG_ADDR_W  source A of IF/ID.
if_id_registerB  in  REG_ADDR_W  source B of IF/ID.
if_id_useA  in  1  source A is actually read.
if_id_useB  in  1  source B is actually read.
branch_taken  in  1  taken branch or jump resolved this cycle.
ex_busy  in  1  multi-cycle EX operation not complete.
perf_clear  in  1  synchronous clear of stall_count.
enablePC  out  1  PC load enable.
if_id_enable  out  1  IF/ID register load enable.
if_id_flush  out  1  IF/ID is cleared to a NOP.
muxSelector  out  1  inject a bubble (zeroed control) into ID/EX.
stall_count  out  CNT_W  cycles with enablePC=0.

Behaviour:
- Load-use hazard, combinational:
  - hz = id_ex_memRead && ((if_id_useA && RD==A) || (if_id_useB && RD==B)).
  - hz is forced to 0 when ZERO_REG_HARDWIRED=1 and RD==0.
- FSM states are RUN, LSTALL and FLUSH. A 4-bit down-counter cnt drives both LSTALL and FLUSH.
- Reset (async, reset_n=0): state=RUN, cnt=0, stall_count=0. Outputs take their RUN/idle values immediately: enablePC=1, if_id_enable=1, if_id_flush=0, muxSelector=0.
- Priority in any state: ex_busy > branch_taken > hazard/counter.
- ex_busy=1 (any state):
  - Outputs: enablePC=0, if_id_enable=0, muxSelector=0, if_id_flush=0.
  - State and cnt are frozen. branch_taken and hz are ignored.
- RUN with branch_taken=1:
  - Outputs: enablePC=1, if_id_flush=1, muxSelector=1, if_id_enable=1.
  - If FLUSH_CYCLES>1: next state FLUSH, cnt=FLUSH_CYCLES-1. Otherwise stay in RUN.
- RUN with hz=1:
  - Outputs: enablePC=0, if_id_enable=0, muxSelector=1, if_id_flush=0.
  - If LOAD_LATENCY>1: next state LSTALL, cnt=LOAD_LATENCY-1. Otherwise stay in RUN.
- RUN otherwise: idle outputs.
- LSTALL:
  - Outputs are the same as RUN with hz=1. hz is not re-evaluated.
  - cnt decrements each cycle. Return to RUN on the cycle after cnt==1.
  - branch_taken=1 in LSTALL preempts: branch outputs that cycle and FLUSH entry exactly as from RUN. The remaining stall is discarded.
- FLUSH:
  - Outputs are the same as RUN with branch_taken=1. cnt decrements; return to RUN after cnt==1.
  - A new branch_taken in FLUSH reloads cnt=FLUSH_CYCLES-1.
  - hz is ignored in FLUSH, because a flushed instruction carries no valid load.
- Each stall window is counted exactly once. A hazard arising on the first RUN cycle after LSTALL is a new hazard and is stalled again.
- stall_count:
  - On a clock edge where enablePC was 0, stall_count increments.
  - It saturates at 2^CNT_W-1.
  - perf_clear has priority and loads 0.
- Outputs are combinational from state, cnt and inputs. There is no output register, so there is zero-cycle latency from hazard detection to stall.

Test Plan:
- LOAD_LATENCY=1, RD=3, A=3, useA=1, memRead=1 for one cycle -> enablePC=0 and muxSelector=1 for exactly 1 cycle; stall_count=1.
- LOAD_LATENCY=3, same hazard -> enablePC=0 and muxSelector=1 for 3 consecutive cycles, then idle; stall_count=3.
- ZERO_REG_HARDWIRED=1, RD=0=A, memRead=1 -> no stall. Repeat with RD=5, B=5, useB=0 -> no stall.
- FLUSH_CYCLES=2, branch_taken pulse -> if_id_flush=1 and muxSelector=1 for 2 cycles with enablePC=1. Second scenario: branch_taken in cycle 2 of a 3-cycle LSTALL -> LSTALL abandoned, 2 flush cycles follow.
- ex_busy=1 for 4 cycles during LSTALL with cnt=2 -> all enables low for 4 cycles, cnt still 2 afterwards, then 2 more stall cycles; stall_count=4 plus the stall cycles.
- reset_n asserted mid-FLUSH -> outputs idle immediately without a clock edge; stall_count=0. With CNT_W=2 and 5 stall cycles -> stall_count=3 (saturated); perf_clear -> 0.
